// File: rtl/spi_seq_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the SPI register sequencer.
// No logic: FSM state encoding, header bit positions, defaults, status-byte layout.
// No flow control; consumed by spi_reg_sequencer and spi_seq_shifter.
package spi_seq_pkg;

   typedef enum logic [1:0] {
      ST_HDR = 2'd0,
      ST_WR  = 2'd1,
      ST_RD  = 2'd2
   } seq_state_t;

   // header byte: {RW, ADDR}
   localparam int HDR_RW_BIT   = 7;
   localparam int DEF_ADDR_W   = 7;
   localparam int DEF_NUM_REGS = 96;

   // status byte shown in the header slot: {err, frame_cnt[2:0], wr_cnt[3:0]}
   localparam int STS_ERR_BIT = 7;
   localparam int STS_FRM_LSB = 4;
   localparam int STS_FRM_W   = 3;
   localparam int STS_WR_LSB  = 0;
   localparam int STS_WR_W    = 4;

   function automatic logic [7:0] status_byte(input logic                 err,
                                              input logic [STS_FRM_W-1:0] frm,
                                              input logic [STS_WR_W-1:0]  wr);
      logic [7:0] s;
      s                          = '0;
      s[STS_ERR_BIT]             = err;
      s[STS_FRM_LSB +: STS_FRM_W] = frm;
      s[STS_WR_LSB +: STS_WR_W]   = wr;
      return s;
   endfunction

endpackage

// File: rtl/spi_seq_shifter.sv
`timescale 1ns/1ps
// Bit counter and MOSI shift register producing one byte per 8 SPI clocks.
// o_byte_vld is high during the 8th bit; o_byte_dat includes the live MOSI bit.
// No backpressure; CS high clears the bit count, reset inside a frame mutes that frame.
module spi_seq_shifter (
   input  logic       w_SPI_Clk,
   input  logic       i_Rst_L,
   input  logic       i_SPI_CS,
   input  logic       i_SPI_MOSI,
   output logic       o_byte_vld,
   output logic [7:0] o_byte_dat
);

   logic       frame_rst_n;
   logic       arm_set_n;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic       ignore_q;

   // frame state is cleared by reset or by CS going high
   assign frame_rst_n = i_Rst_L & ~i_SPI_CS;
   // low only while reset is applied inside an active frame
   assign arm_set_n   = i_Rst_L | i_SPI_CS;

   // next bit count and shift contents
   always_comb begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = {shift_q[5:0], i_SPI_MOSI};
   end

   // bit counter, wraps 7 -> 0 on the byte-completing edge
   always_ff @(posedge w_SPI_Clk or negedge frame_rst_n) begin
      if (!frame_rst_n) bit_cnt_q <= '0;
      else              bit_cnt_q <= bit_cnt_d;
   end

   // shift register; SCLK idles while CS is high so contents are kept between frames
   always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) shift_q <= '0;
      else          shift_q <= shift_d;
   end

   // mute flag: set by a reset landing mid-frame, released when CS next goes high
   always_ff @(posedge w_SPI_Clk or posedge i_SPI_CS or negedge arm_set_n) begin
      if (i_SPI_CS)        ignore_q <= 1'b0;
      else if (!arm_set_n) ignore_q <= 1'b1;
      else                 ignore_q <= ignore_q;
   end

   assign o_byte_vld = (bit_cnt_q == 3'd7) && !ignore_q;
   assign o_byte_dat = {shift_q, i_SPI_MOSI};

endmodule

// File: rtl/spi_reg_sequencer.sv
`timescale 1ns/1ps
// SPI frame sequencer: {RW,ADDR} header then auto-incrementing register data; optional SPI_SEQ_STATUS_EN.
// Write/read results update on the byte-completing SPI edge; read data is fetched with zero added latency.
// No backpressure; writes cross to i_Clk via o_Wr_Toggle, CS high aborts the frame asynchronously.
module spi_reg_sequencer
   import spi_seq_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_REGS = DEF_NUM_REGS
) (
   input  logic              w_SPI_Clk,
   input  logic              i_Rst_L,
   input  logic              i_SPI_CS,
   input  logic              i_SPI_MOSI,
   output logic [7:0]        o_TX_Byte,
   output logic [ADDR_W-1:0] o_Rd_Addr,
   input  logic [7:0]        i_Rd_Data,
   output logic [ADDR_W-1:0] o_Wr_Addr,
   output logic [7:0]        o_Wr_Data,
   output logic              o_Wr_Toggle,
   output logic              o_Err
);

   logic              byte_vld;
   logic [7:0]        byte_dat;
   logic              frame_rst_n;
   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc, hdr_addr;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic [7:0]        tx_q, tx_d, wr_data_q, wr_data_d, hdr_tx;
   logic              wr_tgl_q, wr_tgl_d, err_q, err_d;
   logic              ptr_ok, inc_ok;
`ifdef SPI_SEQ_STATUS_EN
   logic [STS_FRM_W-1:0] frm_cnt_q, frm_cnt_d;
   logic [STS_WR_W-1:0]  wr_cnt_q, wr_cnt_d;
`endif

   spi_seq_shifter u_shifter (
      .w_SPI_Clk  (w_SPI_Clk),
      .i_Rst_L    (i_Rst_L),
      .i_SPI_CS   (i_SPI_CS),
      .i_SPI_MOSI (i_SPI_MOSI),
      .o_byte_vld (byte_vld),
      .o_byte_dat (byte_dat)
   );

   assign frame_rst_n = i_Rst_L & ~i_SPI_CS;
   assign hdr_addr    = byte_dat[ADDR_W-1:0];
   assign ptr_inc     = ptr_q + ADDR_W'(1);
   assign ptr_ok      = (32'(ptr_q) < NUM_REGS);
   assign inc_ok      = (32'(ptr_inc) < NUM_REGS);

`ifdef SPI_SEQ_STATUS_EN
   assign hdr_tx = status_byte(err_q, frm_cnt_q, wr_cnt_q);
`else
   assign hdr_tx = 8'h00;
`endif

   // read address for the next slot; kept apart from the data path so the mux loop stays acyclic
   always_comb begin
      rd_addr_d = rd_addr_q;
      if (byte_vld) begin
         if (state_q == ST_HDR && byte_dat[HDR_RW_BIT]) rd_addr_d = hdr_addr;
         else if (state_q == ST_RD)                     rd_addr_d = ptr_inc;
      end
   end

   // frame decode: header latch, write issue, read fetch, error flag
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      tx_d      = tx_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_tgl_d  = wr_tgl_q;
      err_d     = err_q;
`ifdef SPI_SEQ_STATUS_EN
      frm_cnt_d = frm_cnt_q;
      wr_cnt_d  = wr_cnt_q;
`endif
      if (byte_vld) begin
         case (state_q)
            ST_HDR: begin
               ptr_d = hdr_addr;
               err_d = 1'b0;
`ifdef SPI_SEQ_STATUS_EN
               frm_cnt_d = frm_cnt_q + STS_FRM_W'(1);
`endif
               if (byte_dat[HDR_RW_BIT]) begin
                  state_d = ST_RD;
                  tx_d    = i_Rd_Data;
               end else begin
                  state_d = ST_WR;
                  tx_d    = 8'h00;
               end
            end
            ST_WR: begin
               ptr_d = ptr_inc;
               if (ptr_ok) begin
                  wr_addr_d = ptr_q;
                  wr_data_d = byte_dat;
                  wr_tgl_d  = ~wr_tgl_q;
`ifdef SPI_SEQ_STATUS_EN
                  wr_cnt_d  = wr_cnt_q + STS_WR_W'(1);
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
            ST_RD: begin
               ptr_d = ptr_inc;
               if (inc_ok) begin
                  tx_d = i_Rd_Data;
               end else begin
                  tx_d  = 8'h00;
                  err_d = 1'b1;
               end
            end
            default: state_d = ST_HDR;
         endcase
      end
   end

   // FSM state: back to header decode on reset or CS high
   always_ff @(posedge w_SPI_Clk or negedge frame_rst_n) begin
      if (!frame_rst_n) state_q <= ST_HDR;
      else              state_q <= state_d;
   end

   // registered datapath and outputs; CS high leaves these untouched
   always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         ptr_q     <= '0;
         rd_addr_q <= '0;
         tx_q      <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_tgl_q  <= 1'b0;
         err_q     <= 1'b0;
`ifdef SPI_SEQ_STATUS_EN
         frm_cnt_q <= '0;
         wr_cnt_q  <= '0;
`endif
      end else begin
         ptr_q     <= ptr_d;
         rd_addr_q <= rd_addr_d;
         tx_q      <= tx_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_tgl_q  <= wr_tgl_d;
         err_q     <= err_d;
`ifdef SPI_SEQ_STATUS_EN
         frm_cnt_q <= frm_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
`endif
      end
   end

   // during the last bit the mux is already pointed at the next address so its data lands on that edge
   assign o_Rd_Addr   = byte_vld ? rd_addr_d : rd_addr_q;
   assign o_TX_Byte   = (state_q == ST_HDR) ? hdr_tx : tx_q;
   assign o_Wr_Addr   = wr_addr_q;
   assign o_Wr_Data   = wr_data_q;
   assign o_Wr_Toggle = wr_tgl_q;
   assign o_Err       = err_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for spi_reg_sequencer with a frame-level reference model.
module tb_spi_reg_sequencer;

   localparam int NREG = 96;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cs;
   logic       mosi;
   logic [7:0] tx;
   logic [6:0] rd_addr;
   logic [7:0] rd_data;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_tgl;
   logic       err;

   always #5 clk = ~clk;

   spi_reg_sequencer #(.ADDR_W(7), .NUM_REGS(NREG)) dut (
      .w_SPI_Clk   (clk),
      .i_Rst_L     (rst_n),
      .i_SPI_CS    (cs),
      .i_SPI_MOSI  (mosi),
      .o_TX_Byte   (tx),
      .o_Rd_Addr   (rd_addr),
      .i_Rd_Data   (rd_data),
      .o_Wr_Addr   (wr_addr),
      .o_Wr_Data   (wr_data),
      .o_Wr_Toggle (wr_tgl),
      .o_Err       (err)
   );

   // reference register bank; also serves as the read mux the DUT addresses
   logic [7:0] bank [128];
   assign rd_data = bank[rd_addr];

   int vec = 0;
   int bad = 0;

   // frame-level model state
   logic       m_tgl;
   logic       m_err;
   logic [6:0] m_waddr;
   logic [7:0] m_wdata;
   int         m_frm;
   int         m_wrc;
   logic [7:0] buf_dat [16];

   function automatic logic [7:0] hdr_expect();
`ifdef SPI_SEQ_STATUS_EN
      return {m_err, 3'(m_frm), 4'(m_wrc)};
`else
      return 8'h00;
`endif
   endfunction

   task automatic model_reset();
      m_tgl = 1'b0; m_err = 1'b0; m_waddr = '0; m_wdata = '0; m_frm = 0; m_wrc = 0;
   endtask

   // shift nbits of b MSb first; capture what MISO would carry from o_TX_Byte
   task automatic byte_io(input logic [7:0] b, input int nbits, output logic [7:0] m);
      m = '0;
      for (int i = 0; i < nbits; i++) begin
         mosi     = b[7-i];
         m[7-i]   = tx[7-i];
         @(negedge clk); #1;
      end
   endtask

   task automatic frame_open();
      @(negedge clk); #1;
      cs = 1'b0;
   endtask

   task automatic frame_close();
      cs = 1'b1;
      @(negedge clk); #1;
   endtask

   task automatic run_frame(input logic rw, input logic [6:0] base, input int n);
      logic [7:0] m, exp;
      logic [6:0] a, a1;
      frame_open();
      exp = hdr_expect();
      byte_io({rw, base}, 8, m);
      vec++;
      if (m !== exp) begin
         bad++; $display("FAIL hdr_slot: got %h expected %h", m, exp);
      end
      m_frm++;
      m_err = 1'b0;
      for (int k = 0; k < n; k++) begin
         a  = base + 7'(k);
         a1 = a + 7'd1;
         if (rw) begin
            exp = (k == 0 || a < NREG) ? bank[a] : 8'h00;
            byte_io(buf_dat[k], 8, m);
            vec++;
            if (m !== exp) begin
               bad++; $display("FAIL rd_slot addr %0d: got %h expected %h", a, m, exp);
            end
            if (a1 >= NREG) m_err = 1'b1;
         end else begin
            byte_io(buf_dat[k], 8, m);
            if (a < NREG) begin
               m_tgl = ~m_tgl; m_waddr = a; m_wdata = buf_dat[k]; bank[a] = buf_dat[k]; m_wrc++;
            end else begin
               m_err = 1'b1;
            end
            vec++;
            if (wr_tgl !== m_tgl) begin
               bad++; $display("FAIL wr_toggle addr %0d: got %b expected %b", a, wr_tgl, m_tgl);
            end
            vec++;
            if ({wr_addr, wr_data} !== {m_waddr, m_wdata}) begin
               bad++; $display("FAIL wr_addr_data: got %h/%h expected %h/%h", wr_addr, wr_data, m_waddr, m_wdata);
            end
         end
      end
      vec++;
      if (err !== m_err) begin
         bad++; $display("FAIL err_in_frame: got %b expected %b", err, m_err);
      end
      frame_close();
      vec++;
      if (err !== m_err || wr_tgl !== m_tgl) begin
         bad++; $display("FAIL after_cs_high: got err %b tgl %b expected err %b tgl %b", err, wr_tgl, m_err, m_tgl);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk); #1;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cs = 1'b0; mosi = 1'b0;
      #2 cs = 1'b1;
      model_reset();
      #20;
      vec++;
      if ({tx, rd_addr, wr_addr, wr_data, wr_tgl, err} !== '0) begin
         bad++; $display("FAIL reset_outputs: got tx %h ra %h wa %h wd %h t %b e %b expected all 0", tx, rd_addr, wr_addr, wr_data, wr_tgl, err);
      end
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      vec++;
      if (tx !== 8'h00 || wr_tgl !== 1'b0) begin
         bad++; $display("FAIL reset_release: got tx %h tgl %b expected 00 0", tx, wr_tgl);
      end
   endtask

   task automatic test_write_frame();
      buf_dat[0] = 8'hA5; buf_dat[1] = 8'h3C;
      run_frame(1'b0, 7'h05, 2);
      vec++;
      if ({wr_addr, wr_data, err} !== {7'd6, 8'h3C, 1'b0}) begin
         bad++; $display("FAIL write_last: got %h/%h err %b expected 06/3c err 0", wr_addr, wr_data, err);
      end
   endtask

   task automatic test_read_frame();
      bank[4] = 8'h11; bank[5] = 8'h22;
      buf_dat[0] = 8'h00; buf_dat[1] = 8'h00;
      run_frame(1'b1, 7'h04, 2);
   endtask

   task automatic test_out_of_range();
      logic prev;
      prev = wr_tgl;
      buf_dat[0] = 8'h01; buf_dat[1] = 8'h02;
      run_frame(1'b0, 7'h5F, 2);
      vec++;
      if (wr_tgl !== ~prev || err !== 1'b1 || wr_addr !== 7'd95 || wr_data !== 8'h01) begin
         bad++; $display("FAIL oor_write: got tgl %b err %b %h/%h expected tgl %b err 1 5f/01", wr_tgl, err, wr_addr, wr_data, ~prev);
      end
   endtask

   task automatic test_wrap();
      buf_dat[0] = 8'h9A; buf_dat[1] = 8'h9B; buf_dat[2] = 8'h9C;
      run_frame(1'b0, 7'h7F, 3);
      buf_dat[0] = 8'h00; buf_dat[1] = 8'h00; buf_dat[2] = 8'h00;
      run_frame(1'b1, 7'h5E, 3);
      run_frame(1'b1, 7'h7E, 3);
   endtask

   task automatic test_partial();
      logic [7:0] m;
      frame_open();
      byte_io(8'h02, 8, m);
      m_frm++; m_err = 1'b0;
      byte_io(8'hFF, 5, m);
      frame_close();
      vec++;
      if (wr_tgl !== m_tgl || wr_addr !== m_waddr) begin
         bad++; $display("FAIL partial_byte: got tgl %b addr %h expected tgl %b addr %h", wr_tgl, wr_addr, m_tgl, m_waddr);
      end
      buf_dat[0] = 8'h5A;
      run_frame(1'b0, 7'h02, 1);
   endtask

   task automatic test_reset_mid_write();
      logic [7:0] m;
      frame_open();
      byte_io(8'h03, 8, m);
      byte_io(8'hC3, 4, m);
      rst_n = 1'b0;
      model_reset();
      #1;
      vec++;
      if ({tx, rd_addr, wr_addr, wr_data, wr_tgl, err} !== '0) begin
         bad++; $display("FAIL mid_reset_outputs: got tx %h ra %h wa %h wd %h t %b e %b expected all 0", tx, rd_addr, wr_addr, wr_data, wr_tgl, err);
      end
      @(negedge clk); #1;
      rst_n = 1'b1;
      byte_io(8'h30, 4, m);
      byte_io(8'hFF, 8, m);
      byte_io(8'h81, 8, m);
      vec++;
      if (wr_tgl !== 1'b0 || err !== 1'b0 || tx !== 8'h00) begin
         bad++; $display("FAIL mid_reset_ignored: got tgl %b err %b tx %h expected 0 0 00", wr_tgl, err, tx);
      end
      frame_close();
      buf_dat[0] = 8'h77;
      run_frame(1'b0, 7'h00, 1);
      vec++;
      if ({wr_tgl, wr_addr, wr_data} !== {1'b1, 7'd0, 8'h77}) begin
         bad++; $display("FAIL post_reset_write: got %b %h/%h expected 1 00/77", wr_tgl, wr_addr, wr_data);
      end
   endtask

   task automatic test_status();
      logic [7:0] m, exp;
      apply_reset();
      buf_dat[0] = 8'h21; buf_dat[1] = 8'h43;
      run_frame(1'b0, 7'h10, 2);
`ifdef SPI_SEQ_STATUS_EN
      exp = 8'h12;
`else
      exp = 8'h00;
`endif
      frame_open();
      byte_io(8'h90, 8, m);
      m_frm++; m_err = 1'b0;
      vec++;
      if (m !== exp) begin
         bad++; $display("FAIL status_hdr: got %h expected %h", m, exp);
      end
      frame_close();
   endtask

   task automatic test_random();
      logic       rw;
      logic [6:0] base;
      int         n;
      for (int f = 0; f < 40; f++) begin
         rw   = 1'($urandom_range(0, 1));
         base = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(92, 127)) : 7'($urandom_range(0, 127));
         n    = $urandom_range(0, 4);
         for (int j = 0; j < 16; j++) buf_dat[j] = 8'($urandom);
         run_frame(rw, base, n);
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) bank[i] = 8'($urandom);
      test_reset();
      test_write_frame();
      test_read_frame();
      test_out_of_range();
      test_wrap();
      test_partial();
      test_reset_mid_write();
      test_status();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no completion within 500000ns expected completion");
      $fatal(1, "timeout");
   end

endmodule
